// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and the
// helper that sizes the bit counter.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  // One extra bit so the counter can represent WIDTH itself without wrapping.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// Combinational 1-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor D = X - Y, LSB first, one bit per clock.
// Define SUB_OVF_EN to add the signed-overflow output OVF.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             BOUT
`ifdef SUB_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int CW = cnt_width(WIDTH);

  sub_state_t     state;
  sub_state_t     state_next;
  logic [WIDTH-1:0] x_sr;
  logic [WIDTH-1:0] y_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             d_bit;
  logic             b_out;
  logic             last_bit;
  logic             accept;

`ifdef SUB_OVF_EN
  logic x_msb;
  logic y_msb;
`endif

  full_subtractor_bit u_cell (
    .x    (x_sr[0]),
    .y    (y_sr[0]),
    .bin  (borrow),
    .d    (d_bit),
    .bout (b_out)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign accept   = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result bits shift into the vacated MSB of the minuend register, so after
  // WIDTH shifts x_sr holds the difference; D is copied only on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_sr   <= '0;
      y_sr   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      D      <= '0;
      BOUT   <= 1'b0;
    end else if (accept) begin
      x_sr   <= X;
      y_sr   <= Y;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      x_sr   <= {d_bit, x_sr[WIDTH-1:1]};
      y_sr   <= {1'b0, y_sr[WIDTH-1:1]};
      borrow <= b_out;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        D    <= {d_bit, x_sr[WIDTH-1:1]};
        BOUT <= b_out;
      end
    end
  end

`ifdef SUB_OVF_EN
  // Operand sign bits are shifted out, so keep copies for the overflow test.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_msb <= 1'b0;
      y_msb <= 1'b0;
      OVF   <= 1'b0;
    end else if (accept) begin
      x_msb <= X[WIDTH-1];
      y_msb <= Y[WIDTH-1];
    end else if ((state == SHIFT) && last_bit) begin
      OVF <= (x_msb != y_msb) && (d_bit != x_msb);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Define SUB_OVF_EN to also exercise the overflow output.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             BOUT;
`ifdef SUB_OVF_EN
  logic             OVF;
`endif

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .X     (X),
    .Y     (Y),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .BOUT  (BOUT)
`ifdef SUB_OVF_EN
    ,
    .OVF   (OVF)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge and settle just after it.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present operands with start for exactly one rising edge.
  task automatic start_op(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv);
    X     = xv;
    Y     = yv;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // Bounded wait for done; leaves time at the sample where done is high.
  task automatic wait_done(output int cycles, output int busy_cnt,
                           output logic [WIDTH-1:0] d_obs, output logic b_obs,
                           output bit timed_out);
    cycles   = 0;
    busy_cnt = 0;
    while (!done && cycles < 20) begin
      if (busy) busy_cnt++;
      step(1);
      cycles++;
    end
    timed_out = !done;
    if (busy) busy_cnt++;
    d_obs = D;
    b_obs = BOUT;
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    X     = '0;
    Y     = '0;
    step(2);
    checks++;
    if ({busy, done, D, BOUT} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_state: busy=%b done=%b D=%h BOUT=%b, required 0 0 00 0",
               busy, done, D, BOUT);
    end
`ifdef SUB_OVF_EN
    checks++;
    if (OVF !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ovf: OVF=%b, required 0", OVF);
    end
`endif
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_basic;
    int cyc, bcnt;
    logic [WIDTH-1:0] d_obs;
    logic b_obs;
    bit to;
    start_op(8'h05, 8'h03);
    wait_done(cyc, bcnt, d_obs, b_obs, to);
    checks++;
    if (to) begin
      errors++;
      $display("[TB] FAIL basic_timeout: done not seen within 20 cycles");
    end
    checks++;
    if (cyc !== 8) begin
      errors++;
      $display("[TB] FAIL basic_latency: %0d cycles after start edge, required 8", cyc);
    end
    checks++;
    if (bcnt !== 9) begin
      errors++;
      $display("[TB] FAIL basic_busy_len: busy %0d cycles, required 9", bcnt);
    end
    checks++;
    if ({d_obs, b_obs} !== {8'h02, 1'b0}) begin
      errors++;
      $display("[TB] FAIL basic_result: D=%h BOUT=%b, required 02 0", d_obs, b_obs);
    end
    step(1);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL basic_after_done: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_negative;
    int cyc, bcnt;
    logic [WIDTH-1:0] d_obs;
    logic b_obs;
    bit to;
    start_op(8'h03, 8'h05);
    step(3);
    checks++;
    if ({D, BOUT} !== {8'h02, 1'b0}) begin
      errors++;
      $display("[TB] FAIL neg_hold_during_shift: D=%h BOUT=%b, required 02 0", D, BOUT);
    end
    wait_done(cyc, bcnt, d_obs, b_obs, to);
    checks++;
    if (to || {d_obs, b_obs} !== {8'hFE, 1'b1}) begin
      errors++;
      $display("[TB] FAIL neg_result: D=%h BOUT=%b timeout=%b, required FE 1 0",
               d_obs, b_obs, to);
    end
    step(4);
    checks++;
    if ({D, BOUT, done} !== {8'hFE, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL neg_hold_idle: D=%h BOUT=%b done=%b, required FE 1 0",
               D, BOUT, done);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, bcnt;
    logic [WIDTH-1:0] d_obs;
    logic b_obs;
    bit to;
    start_op(8'h00, 8'h00);
    wait_done(cyc, bcnt, d_obs, b_obs, to);
    checks++;
    if (to || {d_obs, b_obs} !== {8'h00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL b2b_first: D=%h BOUT=%b timeout=%b, required 00 0 0",
               d_obs, b_obs, to);
    end
    step(1);
    start_op(8'hFF, 8'h01);
    wait_done(cyc, bcnt, d_obs, b_obs, to);
    checks++;
    if (to || cyc !== 8 || {d_obs, b_obs} !== {8'hFE, 1'b0}) begin
      errors++;
      $display("[TB] FAIL b2b_second: D=%h BOUT=%b cycles=%0d timeout=%b, required FE 0 8 0",
               d_obs, b_obs, cyc, to);
    end
    step(1);
  endtask

  task automatic test_ignored_start;
    int pulses;
    logic [WIDTH-1:0] d_seen;
    logic b_seen;
    pulses = 0;
    d_seen = '0;
    b_seen = 1'b0;
    start_op(8'h33, 8'h11);
    step(2);
    start_op(8'hAA, 8'h01);
    X = 8'h77;
    Y = 8'hEE;
    for (int i = 0; i < 16; i++) begin
      if (done) begin
        pulses++;
        d_seen = D;
        b_seen = BOUT;
      end
      step(1);
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("[TB] FAIL ignore_done_count: %0d done pulses, required 1", pulses);
    end
    checks++;
    if ({d_seen, b_seen} !== {8'h22, 1'b0}) begin
      errors++;
      $display("[TB] FAIL ignore_result: D=%h BOUT=%b, required 22 0", d_seen, b_seen);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ignore_idle_after: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_abort;
    int pulses, cyc, bcnt;
    logic [WIDTH-1:0] d_obs;
    logic b_obs;
    bit to;
    pulses = 0;
    start_op(8'h44, 8'h04);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if ({busy, done, D, BOUT} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL abort_state: busy=%b done=%b D=%h BOUT=%b, required 0 0 00 0",
               busy, done, D, BOUT);
    end
    for (int i = 0; i < 12; i++) begin
      if (done || busy) pulses++;
      step(1);
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("[TB] FAIL abort_quiet: %0d busy/done samples after abort, required 0", pulses);
    end
    start_op(8'h09, 8'h0A);
    wait_done(cyc, bcnt, d_obs, b_obs, to);
    checks++;
    if (to || {d_obs, b_obs} !== {8'hFF, 1'b1}) begin
      errors++;
      $display("[TB] FAIL abort_recover: D=%h BOUT=%b timeout=%b, required FF 1 0",
               d_obs, b_obs, to);
    end
    step(1);
  endtask

`ifdef SUB_OVF_EN
  task automatic test_ovf;
    int cyc, bcnt;
    logic [WIDTH-1:0] d_obs;
    logic b_obs;
    bit to;
    start_op(8'h80, 8'h01);
    wait_done(cyc, bcnt, d_obs, b_obs, to);
    checks++;
    if (to || {d_obs, b_obs, OVF} !== {8'h7F, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL ovf_set: D=%h BOUT=%b OVF=%b timeout=%b, required 7F 0 1 0",
               d_obs, b_obs, OVF, to);
    end
    step(1);
    start_op(8'h10, 8'h01);
    wait_done(cyc, bcnt, d_obs, b_obs, to);
    checks++;
    if (to || {d_obs, b_obs, OVF} !== {8'h0F, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL ovf_clear: D=%h BOUT=%b OVF=%b timeout=%b, required 0F 0 0 0",
               d_obs, b_obs, OVF, to);
    end
    step(1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_back_to_back();
    test_ignored_start();
    test_abort();
`ifdef SUB_OVF_EN
    test_ovf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
